// File: rtl/sprite_renderer_pkg.sv
// Shared constants and types for the sprite renderer: null/error sprite ids,
// slot edge, transparent colour key, RGB444 type and descriptor FSM states.
package sprite_renderer_pkg;

  localparam logic [5:0] SPRITE_NULL = 6'd63;
  localparam logic [5:0] SPRITE_ERR  = 6'd32;
  localparam int         SLOT        = 32;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t KEY = 12'hF0F;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_ARMED      = 2'd1,
    ST_BLANK      = 2'd2
  } state_e;

  function automatic logic [10:0] clamp_edge(input logic [10:0] v, input int lim);
    return (v > 11'(lim)) ? 11'(lim) : v;
  endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Descriptor, pixel-stream and sprite-ROM signals of one sprite_renderer instance.
// Handshake: no back-pressure; pix_valid qualifies hcount/vcount in the same cycle,
// rom_data answers rom_en one cycle later, outputs are qualified by pix_valid_o.
interface sprite_renderer_if #(
  parameter int ADDR_W = 16
);
  logic              frame_start;
  logic [5:0]        id;
  logic [10:0]       w;
  logic [10:0]       h;
  logic [10:0]       x;
  logic [10:0]       y;
  logic              pix_valid;
  logic [10:0]       hcount;
  logic [10:0]       vcount;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;
  logic              pix_valid_o;
  logic              pixel_hit;
  logic [11:0]       pixel_rgb;

  modport master (
    output frame_start, id, w, h, x, y, pix_valid, hcount, vcount, rom_data,
    input  rom_en, rom_addr, pix_valid_o, pixel_hit, pixel_rgb
  );

  modport slave (
    input  frame_start, id, w, h, x, y, pix_valid, hcount, vcount, rom_data,
    output rom_en, rom_addr, pix_valid_o, pixel_hit, pixel_rgb
  );

endinterface

// File: rtl/sprite_desc_latch.sv
// Per-frame descriptor latch: captures id/position and the slot-clamped box size
// on frame_start and tracks whether a drawable sprite is held.
module sprite_desc_latch
  import sprite_renderer_pkg::*;
#(
  parameter int SLOT_PX = SLOT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_frame_start,
  input  logic [5:0]  i_id,
  input  logic [10:0] i_w,
  input  logic [10:0] i_h,
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  output state_e      o_state,
  output logic [5:0]  o_id,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic [10:0] o_w,
  output logic [10:0] o_h
);

  state_e      r_state;
  state_e      w_next_state;
  logic [5:0]  r_id;
  logic [10:0] r_x, r_y, r_w, r_h;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_WAIT_FRAME;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_frame_start)
      w_next_state = (i_id == SPRITE_NULL) ? ST_BLANK : ST_ARMED;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_id <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_w  <= '0;
      r_h  <= '0;
    end else if (i_frame_start) begin
      r_id <= i_id;
      r_x  <= i_x;
      r_y  <= i_y;
      r_w  <= clamp_edge(i_w, SLOT_PX);
      r_h  <= clamp_edge(i_h, SLOT_PX);
    end
  end

  assign o_state = r_state;
  assign o_id    = r_id;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_w     = r_w;
  assign o_h     = r_h;

endmodule

// File: rtl/sprite_renderer.sv
// One on-screen sprite: 3-stage pipeline turning the pixel stream into ROM reads
// and a colour/hit output. Optional 2x drawing is enabled by SPRITE_SCALE2_EN.
module sprite_renderer
  import sprite_renderer_pkg::state_e, sprite_renderer_pkg::ST_ARMED;
#(
  parameter int          ADDR_W = 16,
  parameter int          SLOT   = sprite_renderer_pkg::SLOT,
  parameter logic [11:0] KEY    = sprite_renderer_pkg::KEY
) (
  input  logic                  clk,
  input  logic                  rstn,
  sprite_renderer_if.slave      bus,
  output state_e                o_dbg_state
);

  state_e      w_state;
  logic [5:0]  w_id;
  logic [10:0] w_x, w_y, w_w, w_h;

  sprite_desc_latch #(.SLOT_PX(SLOT)) u_desc (
    .clk           (clk),
    .rstn          (rstn),
    .i_frame_start (bus.frame_start),
    .i_id          (bus.id),
    .i_w           (bus.w),
    .i_h           (bus.h),
    .i_x           (bus.x),
    .i_y           (bus.y),
    .o_state       (w_state),
    .o_id          (w_id),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_w           (w_w),
    .o_h           (w_h)
  );

  // Offsets keep the borrow bit: pixels left of/above the sprite become huge and
  // can never alias into the box when x+w runs past the 2047 edge.
  logic [11:0] w_dx, w_dy;
  logic [4:0]  w_col, w_row;
  logic        w_in_box;
  logic        w_inside;

  assign w_dx = {1'b0, bus.hcount} - {1'b0, w_x};
  assign w_dy = {1'b0, bus.vcount} - {1'b0, w_y};

`ifdef SPRITE_SCALE2_EN
  assign w_in_box = (w_dx < {w_w, 1'b0}) && (w_dy < {w_h, 1'b0});
  assign w_col    = w_dx[5:1];
  assign w_row    = w_dy[5:1];
`else
  assign w_in_box = (w_dx < {1'b0, w_w}) && (w_dy < {1'b0, w_h});
  assign w_col    = w_dx[4:0];
  assign w_row    = w_dy[4:0];
`endif

  assign w_inside = w_in_box && bus.pix_valid && (w_state == ST_ARMED);

  logic              r_rom_en;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_hit_d1, r_hit_d2, r_hit_d3;
  logic              r_pv_d1, r_pv_d2, r_pv_d3;
  logic [11:0]       r_rgb_d3;
  logic              w_opaque;

  assign w_opaque = r_hit_d2 && (bus.rom_data != KEY);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
      r_hit_d1   <= 1'b0;
      r_hit_d2   <= 1'b0;
      r_hit_d3   <= 1'b0;
      r_pv_d1    <= 1'b0;
      r_pv_d2    <= 1'b0;
      r_pv_d3    <= 1'b0;
      r_rgb_d3   <= '0;
    end else begin
      r_rom_en   <= w_inside;
      r_rom_addr <= ADDR_W'({w_id, w_row, w_col});
      r_hit_d1   <= w_inside;
      r_pv_d1    <= bus.pix_valid;
      r_hit_d2   <= r_hit_d1;
      r_pv_d2    <= r_pv_d1;
      r_hit_d3   <= w_opaque;
      r_pv_d3    <= r_pv_d2;
      r_rgb_d3   <= w_opaque ? bus.rom_data : 12'h000;
    end
  end

  assign bus.rom_en      = r_rom_en;
  assign bus.rom_addr    = r_rom_addr;
  assign bus.pix_valid_o = r_pv_d3;
  assign bus.pixel_hit   = r_hit_d3;
  assign bus.pixel_rgb   = r_rgb_d3;
  assign o_dbg_state     = w_state;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed and randomized bench for sprite_renderer against a geometric reference
// model of sprite coverage, ROM addressing and colour keying.
module tb_sprite_renderer;
  import sprite_renderer_pkg::*;

`ifdef SPRITE_SCALE2_EN
  localparam bit SCALE2 = 1'b1;
`else
  localparam bit SCALE2 = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sprite_renderer_if #(.ADDR_W(16)) bus();
  state_e dbg_state;

  sprite_renderer #(.ADDR_W(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // sprite ROM: synthetic texels, one address forced to the colour key
  logic [15:0] key_addr = 16'hFFFF;

  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    if (a == key_addr) return KEY;
    return 12'((32'(a) * 37 + 11) ^ (32'(a) >> 4));
  endfunction

  always @(posedge clk) begin
    if (!rstn) bus.rom_data <= 12'h000;
    else if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_addr);
  end

  // reference model state
  state_e m_st = ST_WAIT_FRAME;
  int m_id = 0, m_x = 0, m_y = 0, m_w = 0, m_h = 0;
  logic [13:0] exp_q[$];

  int n_asserts = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int hit_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_pix(input bit pv, input int hc, input int vc,
                                    output bit ins, output logic [15:0] addr);
    int ox, oy, lim_w, lim_h, col, row;
    ox = hc - m_x;
    oy = vc - m_y;
    lim_w = SCALE2 ? 2 * m_w : m_w;
    lim_h = SCALE2 ? 2 * m_h : m_h;
    ins = pv && (m_st == ST_ARMED) && ox >= 0 && oy >= 0 && ox < lim_w && oy < lim_h;
    col = SCALE2 ? ((ox >= 0 ? ox : 0) / 2) % 32 : (ox >= 0 ? ox : 0) % 32;
    row = SCALE2 ? ((oy >= 0 ? oy : 0) / 2) % 32 : (oy >= 0 ? oy : 0) % 32;
    addr = 16'(m_id * 1024 + row * 32 + col);
  endfunction

  task automatic set_desc(input int id, input int x, input int y, input int w, input int h);
    bus.id = 6'(id);
    bus.x  = 11'(x);
    bus.y  = 11'(y);
    bus.w  = 11'(w);
    bus.h  = 11'(h);
  endtask

  // driver: one pixel per cycle, checks registered ROM outputs and the 3-deep result
  task automatic step(input bit fs, input bit pv, input int hc, input int vc);
    bit ins, hit;
    logic [15:0] addr;
    logic [11:0] d;
    logic [13:0] e;
    @(negedge clk);
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.hcount      = 11'(hc);
    bus.vcount      = 11'(vc);
    model_pix(pv, hc, vc, ins, addr);
    d = rom_fn(addr);
    hit = ins && (d != KEY);
    exp_q.push_back({pv, hit, hit ? d : 12'h000});
    if (fs) begin
      m_st = (bus.id == SPRITE_NULL) ? ST_BLANK : ST_ARMED;
      m_id = int'(bus.id);
      m_x  = int'(bus.x);
      m_y  = int'(bus.y);
      m_w  = (int'(bus.w) > SLOT) ? SLOT : int'(bus.w);
      m_h  = (int'(bus.h) > SLOT) ? SLOT : int'(bus.h);
    end
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    check("rom_en", 32'(bus.rom_en), 32'(ins));
    if (ins) check("rom_addr", 32'(bus.rom_addr), 32'(addr));
    e = exp_q.pop_front();
    check("pix_valid_o", 32'(bus.pix_valid_o), 32'(e[13]));
    check("pixel_hit", 32'(bus.pixel_hit), 32'(e[12]));
    check("pixel_rgb", 32'(bus.pixel_rgb), 32'(e[11:0]));
    check("state", 32'(dbg_state), 32'(m_st));
    en_cnt  += int'(bus.rom_en);
    hit_cnt += int'(bus.pixel_hit);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_rom_en", 32'(bus.rom_en), 0);
    check("rst_rom_addr", 32'(bus.rom_addr), 0);
    check("rst_pix_valid_o", 32'(bus.pix_valid_o), 0);
    check("rst_pixel_hit", 32'(bus.pixel_hit), 0);
    check("rst_pixel_rgb", 32'(bus.pixel_rgb), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_WAIT_FRAME));
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.frame_start = 1'b0;
    rstn = 1'b1;
    m_st = ST_WAIT_FRAME;
    m_id = 0; m_x = 0; m_y = 0; m_w = 0; m_h = 0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic sweep_row(input int vc, input int h0, input int h1);
    for (int hc = h0; hc <= h1; hc++) step(1'b0, 1'b1, hc, vc);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int rid, rx, ry;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.hcount      = '0;
    bus.vcount      = '0;
    set_desc(0, 0, 0, 0, 0);

    do_reset(3);

    // no descriptor yet: nothing drawn
    sweep_row(0, 0, 10);

    // basic line sweep
    set_desc(16, 100, 50, 16, 16);
    step(1'b1, 1'b0, 0, 0);
    en_cnt = 0; hit_cnt = 0;
    for (int hc = 90; hc <= 140; hc++) begin
      step(1'b0, 1'b1, hc, 50);
      if (hc == 100) check("addr_at_100", 32'(bus.rom_addr), 32'({6'd16, 5'd0, 5'd0}));
    end
    check("row50_en_count", en_cnt, SCALE2 ? 32 : 16);

    // colour key on one texel (row 1, col 3 of sprite 16)
    key_addr = {6'd16, 5'd1, 5'd3};
    hit_cnt = 0;
    sweep_row(51, 95, 140);
    check("row51_hit_count", hit_cnt, SCALE2 ? 32 : 15);
    key_addr = 16'hFFFF;

    // id changes without frame_start: latched id stays in use
    bus.id = 6'd18;
    for (int hc = 98; hc <= 110; hc++) begin
      step(1'b0, 1'b1, hc, 52);
      if (hc == 100) check("addr_id_held", 32'(bus.rom_addr[15:10]), 16);
    end
    step(1'b1, 1'b1, 103, 52);
    check("fs_same_cycle_old_id", 32'(bus.rom_addr[15:10]), 16);
    step(1'b0, 1'b1, 104, 52);
    check("fs_next_cycle_new_id", 32'(bus.rom_addr[15:10]), 18);
    sweep_row(52, 105, 120);

    // null sprite over the same area, with gaps in pix_valid
    set_desc(SPRITE_NULL, 100, 50, 16, 16);
    step(1'b1, 1'b0, 0, 0);
    en_cnt = 0; hit_cnt = 0;
    for (int vc = 48; vc <= 56; vc++)
      for (int hc = 95; hc <= 125; hc++) step(1'b0, 1'($urandom_range(0, 3) != 0), hc, vc);
    check("null_en_count", en_cnt, 0);
    check("null_hit_count", hit_cnt, 0);

    // right-edge clip: wrapped columns are not drawn
    set_desc(5, 2040, 10, 16, 16);
    step(1'b1, 1'b0, 0, 0);
    en_cnt = 0;
    sweep_row(12, 2030, 2047);
    sweep_row(12, 0, 12);
    check("wrap_en_count", en_cnt, 8);

    // zero-size boxes never hit
    set_desc(7, 100, 50, 0, 16);
    step(1'b1, 1'b0, 0, 0);
    en_cnt = 0;
    sweep_row(55, 95, 125);
    set_desc(7, 100, 50, 16, 0);
    step(1'b1, 1'b0, 0, 0);
    sweep_row(50, 95, 125);
    check("zero_size_en_count", en_cnt, 0);

    // box wider than a slot clamps to the slot edge; error sprite draws normally
    set_desc(SPRITE_ERR, 100, 50, 100, 5);
    step(1'b1, 1'b0, 0, 0);
    en_cnt = 0;
    sweep_row(51, 95, 210);
    check("clamp_en_count", en_cnt, SCALE2 ? 64 : 32);

    // 8x8 sprite at the origin; 2x build doubles coverage
    set_desc(3, 0, 0, 8, 8);
    step(1'b1, 1'b0, 0, 0);
    en_cnt = 0;
    for (int vc = 0; vc <= 17; vc++)
      for (int hc = 0; hc <= 17; hc++) begin
        step(1'b0, 1'b1, hc, vc);
        if (vc == 0 && hc == 3)
          check("col_at_h3", 32'(bus.rom_addr[4:0]), SCALE2 ? 1 : 3);
      end
    check("origin_en_count", en_cnt, SCALE2 ? 256 : 64);

    // reset in the middle of a drawn line
    set_desc(16, 100, 50, 16, 16);
    step(1'b1, 1'b0, 0, 0);
    sweep_row(50, 98, 105);
    bus.pix_valid = 1'b1;
    bus.hcount = 11'd106;
    do_reset(1);
    en_cnt = 0;
    sweep_row(50, 98, 120);
    check("post_reset_en_count", en_cnt, 0);

    // randomized descriptors and pixel streams
    for (int r = 0; r < 8; r++) begin
      rid = ($urandom_range(0, 5) == 0) ? 63 : int'($urandom_range(0, 62));
      rx  = int'($urandom_range(0, 2047));
      ry  = int'($urandom_range(0, 2047));
      set_desc(rid, rx, ry, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
      key_addr = {6'(rid), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      step(1'b1, 1'b0, 0, 0);
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 30) == 0)
          set_desc(int'($urandom_range(0, 63)), rx, ry,
                   int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
        step(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) != 0),
             (rx + 2048 - 8 + int'($urandom_range(0, 80))) % 2048,
             (ry + 2048 - 4 + int'($urandom_range(0, 40))) % 2048);
      end
    end

    sweep_row(0, 0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
